// File: rtl/cmp_sort_pkg.sv
// Shared definitions for the compare-and-sort sequencer.
//   WIDTH_DEF / DEPTH_DEF : default value width and buffer depth
//   SWAP_MAX              : saturation value of the swap counter
//   state_t               : controller states (IDLE, SORT, DONE)
package cmp_sort_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int DEPTH_DEF = 8;
  localparam int SWAP_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator, purely combinational.
// Ports:
//   a, b : operands (WIDTH bits)
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
// Exactly one of eq/gt/lt is high for any operand pair.
module mag_cmp #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// File: rtl/cmp_sort_ctrl.sv
// In-place bubble sort of a small value buffer using one shared comparator,
// one compare per clock, with early exit when a pass makes no swaps.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   load_valid   : load_data is valid
//   load_data    : value appended at mem[count]
//   load_ready   : buffer accepts a value (IDLE and not full)
//   start        : begin sorting the loaded entries (IDLE only)
//   busy         : high while in SORT
//   done         : one-cycle pulse when the sort completes
//   rd_addr      : read index
//   rd_data      : mem[rd_addr], combinational, any state
//   count        : number of loaded entries
//   swap_count   : swaps made by the last sort, saturating
//   fsm_state    : current controller state, for observation
// Handshake: a value transfers on a rising edge where load_valid and
// load_ready are both high; load_data must be stable while load_valid is high.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter bit DESCEND = 1'b0,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic [7:0]       swap_count,
  output state_t           fsm_state
);
  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    limit;
  logic             pass_swapped;

  logic [AW-1:0]    idx_next;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             cmp_eq, cmp_gt, cmp_lt;
  logic             out_of_order;
  logic             end_of_pass;
  logic             load_fire;

  assign idx_next = idx + AW'(1);
  assign left     = mem[idx];
  assign right    = mem[idx_next];

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (left),
    .b  (right),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign out_of_order = !cmp_eq && (DESCEND ? cmp_lt : cmp_gt);
  assign end_of_pass  = (idx == limit - AW'(1));

  // Status outputs decode straight from the state register, so they change
  // only on clock edges.
  assign busy       = (state == SORT);
  assign done       = (state == DONE);
  assign load_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  assign rd_data    = mem[rd_addr];
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      swap_count   <= '0;
      idx          <= '0;
      limit        <= '0;
      pass_swapped <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A load in the same cycle as start takes priority.
          if (load_fire) begin
            mem[count[AW-1:0]] <= load_data;
            count              <= count + CW'(1);
          end else if (start) begin
            swap_count   <= '0;
            idx          <= '0;
            limit        <= AW'(count - CW'(1));
            pass_swapped <= 1'b0;
            state        <= (count < CW'(2)) ? DONE : SORT;
          end
        end

        SORT: begin
          if (out_of_order) begin
            mem[idx]      <= right;
            mem[idx_next] <= left;
            pass_swapped  <= 1'b1;
            if (swap_count != 8'(SWAP_MAX)) swap_count <= swap_count + 8'd1;
          end
          if (!end_of_pass) begin
            idx <= idx_next;
          end else if (!(pass_swapped || out_of_order) || limit == AW'(1)) begin
            state <= DONE;
          end else begin
            limit        <= limit - AW'(1);
            idx          <= '0;
            pass_swapped <= 1'b0;
          end
        end

        DONE: begin
          // Sorted data and swap_count stay readable after returning to IDLE.
          state <= IDLE;
          count <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
